// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch initiator with PC, redirect/halt/fault control and decode FIFO
// Optional statistics counters: define FETCH_STATS_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h00400000,
    parameter logic [31:0] MEM_LO_PC  = 32'h00400000,
    parameter logic [31:0] MEM_HI_PC  = 32'h00400400,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic [31:0]                   currPC,
    input  logic [31:0]                   instr,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    input  logic                          halt_req,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_pc,
    output logic [31:0]                   out_instr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fetch_fault
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]                   stat_fetched,
    output logic [31:0]                   stat_flushed,
    output logic [31:0]                   stat_stall_cycles
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [31:0]     pc_q, pc_next;
    logic            fault_q, fault_next;
    logic [31:0]     pc_mem    [FIFO_DEPTH];
    logic [31:0]     instr_mem [FIFO_DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic            pc_legal, full, pop, push;

    assign currPC      = pc_q;
    assign fifo_count  = count;
    assign fetch_fault = fault_q;
    assign out_valid   = (count != '0);
    assign out_pc      = out_valid ? pc_mem[head]    : 32'd0;
    assign out_instr   = out_valid ? instr_mem[head] : 32'd0;

    assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q >= MEM_LO_PC) && (pc_q <= MEM_HI_PC);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = out_valid && out_ready && !redirect_valid;

    // An illegal PC is reported before a halt request is honoured.
    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        fault_next = fault_q;
        push       = 1'b0;
        if (redirect_valid) begin
            state_next = halt_req ? ST_HALT : ST_RUN;
            pc_next    = redirect_pc;
            fault_next = 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!pc_legal) begin
                        state_next = ST_FAULT;
                        fault_next = 1'b1;
                    end else if (halt_req) begin
                        state_next = ST_HALT;
                    end else if (!full || pop) begin
                        push    = 1'b1;
                        pc_next = pc_q + 32'd4;
                    end
                end
                ST_HALT: begin
                    if (!halt_req) state_next = ST_RUN;
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_RUN;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            state   <= state_next;
            pc_q    <= pc_next;
            fault_q <= fault_next;
            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: out_* are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= pc_q;
            instr_mem[tail] <= instr;
        end
    end

`ifdef FETCH_STATS_EN
    logic [32:0] flush_sum;
    logic        stall;

    assign flush_sum = {1'b0, stat_flushed} + 33'(count);
    assign stall     = !redirect_valid && (state == ST_RUN) && pc_legal && !halt_req && full && !pop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_fetched      <= 32'd0;
            stat_flushed      <= 32'd0;
            stat_stall_cycles <= 32'd0;
        end else begin
            if (push && stat_fetched != 32'hFFFFFFFF)
                stat_fetched <= stat_fetched + 32'd1;
            if (redirect_valid)
                stat_flushed <= flush_sum[32] ? 32'hFFFFFFFF : flush_sum[31:0];
            if (stall && stat_stall_cycles != 32'hFFFFFFFF)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
